// File: rtl/vx_tex_mem_arb_if.sv
// Bundle of sampler-side and tex-mem-side handshake signals for vx_tex_mem_arb.
// The arbiter connects through the slave modport; the environment uses master.
interface vx_tex_mem_arb_if #(
    parameter int NUM_REQS      = 4,
    parameter int NUM_LANES     = 4,
    parameter int REQ_INFOW     = 8,
    parameter int W_ADDR_BITS   = 38,
    parameter int FILTER_BITS   = 1,
    parameter int LGSTRIDE_BITS = 2
);
    localparam int IDXW      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int OUT_INFOW = REQ_INFOW + IDXW;

    // Per-sampler request side
    logic [NUM_REQS-1:0]                                   req_valid;
    logic [NUM_REQS-1:0][NUM_LANES-1:0]                    req_mask;
    logic [NUM_REQS-1:0][FILTER_BITS-1:0]                  req_filter;
    logic [NUM_REQS-1:0][LGSTRIDE_BITS-1:0]                req_lgstride;
    logic [NUM_REQS-1:0][NUM_LANES-1:0][W_ADDR_BITS-1:0]   req_baseaddr;
    logic [NUM_REQS-1:0][NUM_LANES-1:0][3:0][31:0]         req_addr;
    logic [NUM_REQS-1:0][REQ_INFOW-1:0]                    req_info;
    logic [NUM_REQS-1:0]                                   req_ready;

    // Shared tex mem request
    logic                                  mem_req_valid;
    logic [NUM_LANES-1:0]                  mem_req_mask;
    logic [FILTER_BITS-1:0]                mem_req_filter;
    logic [LGSTRIDE_BITS-1:0]              mem_req_lgstride;
    logic [NUM_LANES-1:0][W_ADDR_BITS-1:0] mem_req_baseaddr;
    logic [NUM_LANES-1:0][3:0][31:0]       mem_req_addr;
    logic [OUT_INFOW-1:0]                  mem_req_info;
    logic                                  mem_req_ready;

    // Shared tex mem response
    logic                            mem_rsp_valid;
    logic [NUM_LANES-1:0][3:0][31:0] mem_rsp_data;
    logic [OUT_INFOW-1:0]            mem_rsp_info;
    logic                            mem_rsp_ready;

    // Per-sampler response side
    logic [NUM_REQS-1:0]             rsp_valid;
    logic [NUM_LANES-1:0][3:0][31:0] rsp_data;
    logic [REQ_INFOW-1:0]            rsp_info;
    logic [NUM_REQS-1:0]             rsp_ready;

    modport slave (
        input  req_valid, req_mask, req_filter, req_lgstride, req_baseaddr, req_addr, req_info,
        output req_ready,
        output mem_req_valid, mem_req_mask, mem_req_filter, mem_req_lgstride,
               mem_req_baseaddr, mem_req_addr, mem_req_info,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_info,
        output mem_rsp_ready,
        output rsp_valid, rsp_data, rsp_info,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_mask, req_filter, req_lgstride, req_baseaddr, req_addr, req_info,
        input  req_ready,
        input  mem_req_valid, mem_req_mask, mem_req_filter, mem_req_lgstride,
               mem_req_baseaddr, mem_req_addr, mem_req_info,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_info,
        input  mem_rsp_ready,
        input  rsp_valid, rsp_data, rsp_info,
        output rsp_ready
    );
endinterface

// File: rtl/vx_tex_mem_arb.sv
// Texture memory arbiter: round-robin selects one sampler request per cycle into a single
// registered stage, tags it with the source index, routes in-order responses back by that
// index, and limits each source to MAX_PENDING outstanding requests.
module vx_tex_mem_arb #(
    parameter int NUM_REQS      = 4,
    parameter int NUM_LANES     = 4,
    parameter int REQ_INFOW     = 8,
    parameter int W_ADDR_BITS   = 38,
    parameter int FILTER_BITS   = 1,
    parameter int LGSTRIDE_BITS = 2,
    parameter int MAX_PENDING   = 8
) (
    input  logic            clk,
    input  logic            reset,
    vx_tex_mem_arb_if.slave bus
);
    localparam int IDXW      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int OUT_INFOW = REQ_INFOW + IDXW;
    localparam int PCW       = $clog2(MAX_PENDING + 1);

    localparam logic [PCW-1:0]  MAX_PCNT = PCW'(MAX_PENDING);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQS - 1);

    // Position 'off' steps after 'base' in the round-robin ring
    function automatic logic [IDXW-1:0] rr_slot(input logic [IDXW-1:0] base, input int off);
        int c;
        c = int'(base) + off;
        if (c >= NUM_REQS) c = c - NUM_REQS;
        return IDXW'(c);
    endfunction

    logic [NUM_REQS-1:0][PCW-1:0] pending;
    logic [IDXW-1:0]              rr_ptr;

    logic [NUM_REQS-1:0] eligible;
    logic [NUM_REQS-1:0] grant;
    logic [NUM_REQS-1:0] req_fire;
    logic [NUM_REQS-1:0] rsp_fire;
    logic [IDXW-1:0]     grant_idx;
    logic [IDXW-1:0]     cand;
    logic                any_elig;
    logic                stage_free;
    logic                accept;
    logic [IDXW-1:0]     rsp_idx;
    logic                rsp_known;

    logic                                  vld_p1;
    logic [NUM_LANES-1:0]                  mask_p1;
    logic [FILTER_BITS-1:0]                filter_p1;
    logic [LGSTRIDE_BITS-1:0]              lgstride_p1;
    logic [NUM_LANES-1:0][W_ADDR_BITS-1:0] baseaddr_p1;
    logic [NUM_LANES-1:0][3:0][31:0]       addr_p1;
    logic [OUT_INFOW-1:0]                  info_p1;

    // A source may compete only while it has credit left
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = bus.req_valid[i] && (pending[i] < MAX_PCNT);
        end
    end

    // Round-robin pick: first eligible source starting at rr_ptr
    always_comb begin
        any_elig  = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int j = 0; j < NUM_REQS; j++) begin
            cand = rr_slot(rr_ptr, j);
            if (!any_elig && eligible[cand]) begin
                any_elig  = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // One-hot grant, acceptance and per-source request handshakes
    always_comb begin
        stage_free = !vld_p1 || bus.mem_req_ready;
        accept     = any_elig && stage_free && !reset;
        grant      = '0;
        req_fire   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            grant[i]    = any_elig && (grant_idx == IDXW'(i));
            req_fire[i] = accept && grant[i];
        end
    end

    assign bus.req_ready = req_fire;

    // Request stage valid: loads on accept, clears once the tex mem takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (stage_free) begin
            vld_p1 <= any_elig;
        end
    end

    // Request stage payload: captured from the granted source, held while stalled
    always_ff @(posedge clk) begin
        if (accept) begin
            mask_p1     <= bus.req_mask[grant_idx];
            filter_p1   <= bus.req_filter[grant_idx];
            lgstride_p1 <= bus.req_lgstride[grant_idx];
            baseaddr_p1 <= bus.req_baseaddr[grant_idx];
            addr_p1     <= bus.req_addr[grant_idx];
            info_p1     <= {bus.req_info[grant_idx], grant_idx};
        end
    end

    assign bus.mem_req_valid    = vld_p1;
    assign bus.mem_req_mask     = mask_p1;
    assign bus.mem_req_filter   = filter_p1;
    assign bus.mem_req_lgstride = lgstride_p1;
    assign bus.mem_req_baseaddr = baseaddr_p1;
    assign bus.mem_req_addr     = addr_p1;
    assign bus.mem_req_info     = info_p1;

    // Round-robin pointer moves just past the last accepted source
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDXW'(1);
        end
    end

    // Response routing: the low info bits select the destination source
    always_comb begin
        rsp_idx       = (NUM_REQS == 1) ? '0 : bus.mem_rsp_info[IDXW-1:0];
        bus.rsp_valid = '0;
        bus.mem_rsp_ready = 1'b0;
        rsp_known     = 1'b0;
        rsp_fire      = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (rsp_idx == IDXW'(k)) begin
                bus.rsp_valid[k]  = bus.mem_rsp_valid;
                bus.mem_rsp_ready = bus.rsp_ready[k];
                rsp_known         = (pending[k] != '0);
                rsp_fire[k]       = bus.mem_rsp_valid && bus.rsp_ready[k];
            end
        end
    end

    assign bus.rsp_data = bus.mem_rsp_data;
    assign bus.rsp_info = bus.mem_rsp_info[OUT_INFOW-1:IDXW];

    // Credit counters: up on accept, down on response handshake, unchanged when both
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                case ({req_fire[i], rsp_fire[i]})
                    2'b10:   pending[i] <= pending[i] + PCW'(1);
                    2'b01:   pending[i] <= pending[i] - PCW'(1);
                    default: pending[i] <= pending[i];
                endcase
            end
        end
    end

    // A response must target a real source that has a request outstanding
    always_ff @(posedge clk) begin
        if (!reset && bus.mem_rsp_valid) begin
            assert (rsp_known)
                else $error("vx_tex_mem_arb: response for source %0d with nothing pending", rsp_idx);
        end
    end
endmodule

// File: tb/tb_vx_tex_mem_arb.sv
// Directed bench for vx_tex_mem_arb: a reference model of the arbiter drives an
// expected-request queue checked against the tex mem request port, plus response routing
// and credit-counter checks. A second instance with MAX_PENDING=2 covers credit exhaustion.
module tb_vx_tex_mem_arb;
    localparam int NR     = 4;
    localparam int NL     = 4;
    localparam int IW     = 8;
    localparam int AW     = 38;
    localparam int FB     = 1;
    localparam int LB     = 2;
    localparam int MAXP_A = 8;
    localparam int MAXP_B = 2;

    typedef struct {
        logic [9:0]  info;
        logic [3:0]  mask;
        logic [0:0]  filter;
        logic [1:0]  lgstride;
        logic [37:0] base0;
        logic [31:0] addr_lo;
        logic [31:0] addr_hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   vectors     = 0;
    int   miscompares = 0;

    int   m_rr;
    int   m_pend[NR];
    exp_t exp_q[$];

    vx_tex_mem_arb_if #(.NUM_REQS(NR), .NUM_LANES(NL), .REQ_INFOW(IW), .W_ADDR_BITS(AW),
                        .FILTER_BITS(FB), .LGSTRIDE_BITS(LB)) ifa ();
    vx_tex_mem_arb_if #(.NUM_REQS(NR), .NUM_LANES(NL), .REQ_INFOW(IW), .W_ADDR_BITS(AW),
                        .FILTER_BITS(FB), .LGSTRIDE_BITS(LB)) ifb ();

    vx_tex_mem_arb #(.NUM_REQS(NR), .NUM_LANES(NL), .REQ_INFOW(IW), .W_ADDR_BITS(AW),
                     .FILTER_BITS(FB), .LGSTRIDE_BITS(LB), .MAX_PENDING(MAXP_A))
        dut_a (.clk(clk), .reset(rst_a), .bus(ifa));

    vx_tex_mem_arb #(.NUM_REQS(NR), .NUM_LANES(NL), .REQ_INFOW(IW), .W_ADDR_BITS(AW),
                     .FILTER_BITS(FB), .LGSTRIDE_BITS(LB), .MAX_PENDING(MAXP_B))
        dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
            else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic clear_inputs();
        ifa.req_valid = '0; ifa.req_mask = '0; ifa.req_filter = '0; ifa.req_lgstride = '0;
        ifa.req_baseaddr = '0; ifa.req_addr = '0; ifa.req_info = '0;
        ifa.mem_req_ready = 1'b0; ifa.mem_rsp_valid = 1'b0; ifa.mem_rsp_data = '0;
        ifa.mem_rsp_info = '0; ifa.rsp_ready = '0;
        ifb.req_valid = '0; ifb.req_mask = '0; ifb.req_filter = '0; ifb.req_lgstride = '0;
        ifb.req_baseaddr = '0; ifb.req_addr = '0; ifb.req_info = '0;
        ifb.mem_req_ready = 1'b0; ifb.mem_rsp_valid = 1'b0; ifb.mem_rsp_data = '0;
        ifb.mem_rsp_info = '0; ifb.rsp_ready = '0;
    endtask

    task automatic new_payload_a();
        for (int i = 0; i < NR; i++) begin
            ifa.req_mask[i]     = 4'($urandom);
            ifa.req_filter[i]   = 1'($urandom);
            ifa.req_lgstride[i] = 2'($urandom);
            ifa.req_info[i]     = 8'($urandom);
            for (int l = 0; l < NL; l++) begin
                ifa.req_baseaddr[i][l] = 38'({$urandom, $urandom});
                for (int q = 0; q < 4; q++) ifa.req_addr[i][l][q] = $urandom;
            end
        end
        for (int l = 0; l < NL; l++)
            for (int q = 0; q < 4; q++) ifa.mem_rsp_data[l][q] = $urandom;
    endtask

    // One cycle of instance A: check against the model, then advance the model and clock.
    // Entered at posedge+1 with inputs already driven.
    task automatic run_a();
        int         g;
        bit         any;
        bit         free;
        int         idx;
        logic [3:0] exp_rdy;
        logic [3:0] exp_rv;
        exp_t       e;
        #1;
        free = (exp_q.size() == 0) || (ifa.mem_req_ready === 1'b1);
        any  = 1'b0;
        g    = 0;
        for (int j = 0; j < NR; j++) begin
            int c;
            c = (m_rr + j) % NR;
            if (!any && ifa.req_valid[c] && m_pend[c] < MAXP_A) begin
                any = 1'b1;
                g   = c;
            end
        end
        exp_rdy = (any && free && !rst_a) ? 4'(1 << g) : 4'd0;
        chk("req_ready", 64'(ifa.req_ready), 64'(exp_rdy));
        chk("mem_req_valid", 64'(ifa.mem_req_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("mem_req_info", 64'(ifa.mem_req_info), 64'(e.info));
            chk("mem_req_mask", 64'(ifa.mem_req_mask), 64'(e.mask));
            chk("mem_req_filter", 64'(ifa.mem_req_filter), 64'(e.filter));
            chk("mem_req_lgstride", 64'(ifa.mem_req_lgstride), 64'(e.lgstride));
            chk("mem_req_base0", 64'(ifa.mem_req_baseaddr[0]), 64'(e.base0));
            chk("mem_req_addr00", 64'(ifa.mem_req_addr[0][0]), 64'(e.addr_lo));
            chk("mem_req_addr33", 64'(ifa.mem_req_addr[3][3]), 64'(e.addr_hi));
        end
        for (int i = 0; i < NR; i++) chk($sformatf("pending%0d", i), 64'(dut_a.pending[i]), 64'(m_pend[i]));

        idx    = int'(ifa.mem_rsp_info[1:0]);
        exp_rv = ifa.mem_rsp_valid ? 4'(1 << idx) : 4'd0;
        chk("rsp_valid", 64'(ifa.rsp_valid), 64'(exp_rv));
        chk("mem_rsp_ready", 64'(ifa.mem_rsp_ready), 64'(ifa.rsp_ready[idx]));
        if (ifa.mem_rsp_valid) begin
            chk("rsp_info", 64'(ifa.rsp_info), 64'(ifa.mem_rsp_info[9:2]));
            chk("rsp_data", 64'(ifa.rsp_data[2][1]), 64'(ifa.mem_rsp_data[2][1]));
        end

        if (rst_a) begin
            exp_q.delete();
            m_rr = 0;
            for (int i = 0; i < NR; i++) m_pend[i] = 0;
        end else begin
            if (exp_q.size() != 0 && ifa.mem_req_ready) void'(exp_q.pop_front());
            if (any && free) begin
                e.info     = {ifa.req_info[g], 2'(g)};
                e.mask     = ifa.req_mask[g];
                e.filter   = ifa.req_filter[g];
                e.lgstride = ifa.req_lgstride[g];
                e.base0    = ifa.req_baseaddr[g][0];
                e.addr_lo  = ifa.req_addr[g][0][0];
                e.addr_hi  = ifa.req_addr[g][3][3];
                exp_q.push_back(e);
                m_pend[g]++;
                m_rr = (g + 1) % NR;
            end
            if (ifa.mem_rsp_valid && ifa.rsp_ready[idx]) m_pend[idx]--;
        end
        @(posedge clk);
        #1;
    endtask

    // One directed cycle of instance B (only source 1 is ever used there)
    task automatic cyc_b(input string tag, input logic [3:0] rdy_exp, input logic vld_exp);
        #1;
        chk({tag, ".req_ready"}, 64'(ifb.req_ready), 64'(rdy_exp));
        chk({tag, ".mem_req_valid"}, 64'(ifb.mem_req_valid), 64'(vld_exp));
        if (vld_exp) chk({tag, ".src"}, 64'(ifb.mem_req_info[1:0]), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_rr = 0;
        for (int i = 0; i < NR; i++) m_pend[i] = 0;
        clear_inputs();
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Credit exhaustion on instance B (MAX_PENDING=2), source 1 only
        rst_b = 1'b0;
        ifb.req_valid     = 4'b0010;
        ifb.req_info[1]   = 8'h11;
        ifb.mem_req_ready = 1'b1;
        cyc_b("t3_acc0", 4'b0010, 1'b0);
        cyc_b("t3_acc1", 4'b0010, 1'b1);
        cyc_b("t3_full", 4'b0000, 1'b1);
        cyc_b("t3_hold", 4'b0000, 1'b0);
        chk("t3_pend_full", 64'(dut_b.pending[1]), 64'd2);
        ifb.mem_rsp_valid = 1'b1;
        ifb.mem_rsp_info  = {8'h3C, 2'd1};
        ifb.rsp_ready     = 4'b0010;
        #1;
        chk("t3_rsp_valid", 64'(ifb.rsp_valid), 64'(4'b0010));
        chk("t3_mem_rsp_ready", 64'(ifb.mem_rsp_ready), 64'd1);
        chk("t3_rsp_info", 64'(ifb.rsp_info), 64'(8'h3C));
        cyc_b("t3_rsp", 4'b0000, 1'b0);
        ifb.mem_rsp_valid = 1'b0;
        ifb.rsp_ready     = 4'b0000;
        cyc_b("t3_again", 4'b0010, 1'b0);
        ifb.req_valid = 4'b0000;
        cyc_b("t3_drain", 4'b0000, 1'b1);
        chk("t3_pend_end", 64'(dut_b.pending[1]), 64'd2);

        // Reset state of instance A with every source requesting
        ifa.req_valid = 4'hF;
        new_payload_a();
        run_a();

        // All sources valid, tex mem always ready: grants rotate 0,1,2,3,...
        rst_a = 1'b0;
        ifa.mem_req_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            new_payload_a();
            run_a();
        end

        // Tex mem stalls for 5 cycles with the stage full, then releases
        ifa.mem_req_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            new_payload_a();
            run_a();
        end
        ifa.mem_req_ready = 1'b1;
        new_payload_a();
        run_a();
        new_payload_a();
        run_a();

        // Response to source 3 held off by rsp_ready, then released
        ifa.req_valid     = 4'h0;
        ifa.mem_rsp_valid = 1'b1;
        ifa.mem_rsp_info  = {8'hA5, 2'd3};
        ifa.rsp_ready     = 4'b0000;
        #1;
        chk("t5_rsp_valid", 64'(ifa.rsp_valid), 64'(4'b1000));
        chk("t5_rsp_info", 64'(ifa.rsp_info), 64'(8'hA5));
        chk("t5_mem_rsp_ready_lo", 64'(ifa.mem_rsp_ready), 64'd0);
        run_a();
        ifa.rsp_ready = 4'b1000;
        #1;
        chk("t5_mem_rsp_ready_hi", 64'(ifa.mem_rsp_ready), 64'd1);
        run_a();
        ifa.mem_rsp_valid = 1'b0;
        ifa.rsp_ready     = 4'b0000;
        run_a();

        // Build pending = {3,1,0,2} with the stage full, then reset mid-operation
        rst_a = 1'b1;
        run_a();
        rst_a = 1'b0;
        for (int n = 0; n < 6; n++) begin
            ifa.req_valid = (n < 3) ? 4'b0001 : ((n == 3) ? 4'b0010 : 4'b1000);
            new_payload_a();
            run_a();
        end
        ifa.req_valid     = 4'b0000;
        ifa.mem_req_ready = 1'b0;
        run_a();
        chk("t6_pend0", 64'(dut_a.pending[0]), 64'd3);
        chk("t6_pend1", 64'(dut_a.pending[1]), 64'd1);
        chk("t6_pend2", 64'(dut_a.pending[2]), 64'd0);
        chk("t6_pend3", 64'(dut_a.pending[3]), 64'd2);
        chk("t6_stage_full", 64'(ifa.mem_req_valid), 64'd1);
        rst_a = 1'b1;
        ifa.req_valid = 4'hF;
        run_a();
        rst_a = 1'b0;
        ifa.req_valid     = 4'b0110;
        ifa.mem_req_ready = 1'b1;
        #1;
        chk("t6_post_valid", 64'(ifa.mem_req_valid), 64'd0);
        chk("t6_first_grant", 64'(ifa.req_ready), 64'(4'b0010));
        run_a();

        // Accept and response for source 2 in the same cycle with pending[2]=1
        ifa.req_valid = 4'b0100;
        new_payload_a();
        run_a();
        ifa.mem_rsp_valid = 1'b1;
        ifa.mem_rsp_info  = {8'h5A, 2'd2};
        ifa.rsp_ready     = 4'b0100;
        new_payload_a();
        run_a();
        ifa.req_valid     = 4'b0000;
        ifa.mem_rsp_valid = 1'b0;
        ifa.rsp_ready     = 4'b0000;
        chk("t4_pend2", 64'(dut_a.pending[2]), 64'd1);
        run_a();
        run_a();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
